// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Control-state sequencer for the processor. Walks each instruction
//            through FETCH1..FETCH3, DECODE and a per-opcode execute chain, and
//            presents the 6-bit state code that control_unit decodes into
//            datapath strobes. Counts decoded instructions and flags undefined
//            opcodes and memory timeouts.
// Revision : 1.0 - initial release
//
// Configuration macro:
//   SEQ_WAIT_EN - when defined, LOAD2 and STORE2 stretch until mem_ready=1,
//                 with a WAIT_MAX-cycle timeout that sets timeout_err and
//                 parks the sequencer in HALT. When undefined, mem_ready is
//                 ignored and timeout_err is tied low.
//
// Ports:
//   clock       in   1        system clock, rising edge
//   reset       in   1        asynchronous, active-high
//   run         in   1        start/resume request (used in IDLE and HALT)
//   ir_opcode   in   OP_W     IR[15:12], sampled only in DECODE
//   z_flag      in   1        accumulator-zero flag, sampled only in DECODE
//   mem_ready   in   1        DRAM access complete (SEQ_WAIT_EN only)
//   state       out  STATE_W  current state code
//   busy        out  1        state is neither IDLE nor HALT
//   halted      out  1        state is HALT
//   illegal_op  out  1        one-cycle pulse after decoding opcode 7..E
//   timeout_err out  1        sticky memory-timeout flag
//   instr_count out  CNT_W    number of instructions decoded (wrapping)
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter int STATE_W  = 6,
    parameter int OP_W     = 4,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [OP_W-1:0]    ir_opcode,
    input  logic               z_flag,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               halted,
    output logic               illegal_op,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   instr_count
);

    // State codes are fixed by control_unit's decode table.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 6'd0,
        S_FETCH1 = 6'd1,
        S_FETCH2 = 6'd2,
        S_FETCH3 = 6'd3,
        S_DECODE = 6'd4,
        S_LOAD1  = 6'd8,
        S_LOAD2  = 6'd9,
        S_LOAD3  = 6'd10,
        S_STORE1 = 6'd12,
        S_STORE2 = 6'd13,
        S_ADD1   = 6'd16,
        S_ADD2   = 6'd17,
        S_SUB1   = 6'd20,
        S_SUB2   = 6'd21,
        S_JMP1   = 6'd24,
        S_JZ1    = 6'd28,
        S_HALT   = 6'd63
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   nxt_illegal;
    logic   count_inc;
    logic   nxt_timeout;

`ifdef SEQ_WAIT_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hold;
    logic              timeout_q;

    // A memory step either advances (ready wins even on the limit cycle),
    // times out on the WAIT_MAX-th consecutive not-ready cycle, or holds.
    function automatic state_t mem_step(input state_t here, input state_t after);
        if (mem_ready)
            return after;
        else if (wait_cnt == WAIT_W'(WAIT_MAX - 1))
            return S_HALT;
        else
            return here;
    endfunction
`else
    // mem_ready and WAIT_MAX only matter when memory wait states are enabled.
    logic unused_wait_cfg;
    assign unused_wait_cfg = mem_ready ^ (WAIT_MAX == 0);
`endif

    always_comb begin
        nxt_state   = cur_state;
        nxt_illegal = 1'b0;
        count_inc   = 1'b0;
        nxt_timeout = 1'b0;
`ifdef SEQ_WAIT_EN
        wait_hold   = 1'b0;
`endif
        case (cur_state)
            S_IDLE:   if (run) nxt_state = S_FETCH1;
            S_FETCH1: nxt_state = S_FETCH2;
            S_FETCH2: nxt_state = S_FETCH3;
            S_FETCH3: begin
                nxt_state = S_DECODE;
                count_inc = 1'b1;
            end
            S_DECODE: begin
                case (ir_opcode)
                    OP_W'(0):  nxt_state = S_FETCH1;
                    OP_W'(1):  nxt_state = S_LOAD1;
                    OP_W'(2):  nxt_state = S_STORE1;
                    OP_W'(3):  nxt_state = S_ADD1;
                    OP_W'(4):  nxt_state = S_SUB1;
                    OP_W'(5):  nxt_state = S_JMP1;
                    OP_W'(6):  nxt_state = z_flag ? S_JZ1 : S_FETCH1;
                    OP_W'(15): nxt_state = S_HALT;
                    default: begin
                        nxt_state   = S_FETCH1;
                        nxt_illegal = 1'b1;
                    end
                endcase
            end
            S_LOAD1:  nxt_state = S_LOAD2;
`ifdef SEQ_WAIT_EN
            S_LOAD2: begin
                nxt_state   = mem_step(S_LOAD2, S_LOAD3);
                wait_hold   = (nxt_state == S_LOAD2);
                nxt_timeout = (nxt_state == S_HALT);
            end
            S_STORE2: begin
                nxt_state   = mem_step(S_STORE2, S_FETCH1);
                wait_hold   = (nxt_state == S_STORE2);
                nxt_timeout = (nxt_state == S_HALT);
            end
`else
            S_LOAD2:  nxt_state = S_LOAD3;
            S_STORE2: nxt_state = S_FETCH1;
`endif
            S_LOAD3:  nxt_state = S_FETCH1;
            S_STORE1: nxt_state = S_STORE2;
            S_ADD1:   nxt_state = S_ADD2;
            S_ADD2:   nxt_state = S_FETCH1;
            S_SUB1:   nxt_state = S_SUB2;
            S_SUB2:   nxt_state = S_FETCH1;
            S_JMP1:   nxt_state = S_FETCH1;
            S_JZ1:    nxt_state = S_FETCH1;
            S_HALT:   if (run) nxt_state = S_FETCH1;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state code in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state   <= S_IDLE;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
`ifdef SEQ_WAIT_EN
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            cur_state   <= nxt_state;
            busy        <= (nxt_state != S_IDLE) && (nxt_state != S_HALT);
            halted      <= (nxt_state == S_HALT);
            illegal_op  <= nxt_illegal;
            if (count_inc)
                instr_count <= instr_count + 1'b1;
`ifdef SEQ_WAIT_EN
            wait_cnt    <= wait_hold ? wait_cnt + 1'b1 : '0;
            timeout_q   <= timeout_q | nxt_timeout;
`endif
        end
    end

    assign state = cur_state;

`ifdef SEQ_WAIT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
    logic unused_timeout;
    assign unused_timeout = nxt_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none

module tb_instr_sequencer;

    localparam int WAIT_MAX = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  ir_opcode = 4'd0;
    logic        z_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic [5:0]  state;
    logic        busy;
    logic        halted;
    logic        illegal_op;
    logic        timeout_err;
    logic [15:0] instr_count;

    instr_sequencer #(
        .STATE_W (6),
        .OP_W    (4),
        .CNT_W   (16),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .z_flag     (z_flag),
        .mem_ready  (mem_ready),
        .state      (state),
        .busy       (busy),
        .halted     (halted),
        .illegal_op (illegal_op),
        .timeout_err(timeout_err),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each instruction is expanded into the list of state
    // codes it occupies (one entry per cycle) from the opcode rules.
    typedef struct {
        logic [5:0] st;
        logic       mr;   // mem_ready to present while in this step
        logic       to;   // entering this step raises timeout_err
    } step_t;

    step_t       seq[$];
    logic [5:0]  m_state = 6'd0;
    logic [15:0] m_count = 16'd0;
    logic        m_timeout = 1'b0;
    logic        m_ill_pending = 1'b0;
    logic [3:0]  m_op = 4'd0;     // opcode of instruction currently in DECODE
    logic        m_z = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input logic exp_ill);
        chk("state", 32'(state), 32'(m_state));
        chk("busy", 32'(busy), 32'(m_state != 6'd0 && m_state != 6'd63));
        chk("halted", 32'(halted), 32'(m_state == 6'd63));
        chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
        chk("timeout_err", 32'(timeout_err), 32'(m_timeout));
        chk("instr_count", 32'(instr_count), 32'(m_count));
    endtask

    task automatic push_step(input logic [5:0] st, input logic mr, input logic to);
        step_t s;
        s.st = st;
        s.mr = mr;
        s.to = to;
        seq.push_back(s);
    endtask

    // Memory step followed by an optional successor (0 = none).
    task automatic push_mem(input logic [5:0] st, input int waits, input logic [5:0] after);
`ifdef SEQ_WAIT_EN
        if (waits >= WAIT_MAX) begin
            repeat (WAIT_MAX) push_step(st, 1'b0, 1'b0);
            push_step(6'd63, 1'($urandom), 1'b1);
        end else begin
            repeat (waits) push_step(st, 1'b0, 1'b0);
            push_step(st, 1'b1, 1'b0);
            if (after != 6'd0) push_step(after, 1'($urandom), 1'b0);
        end
`else
        if (waits < 0) $display("note: negative wait count ignored");
        push_step(st, 1'($urandom), 1'b0);
        if (after != 6'd0) push_step(after, 1'($urandom), 1'b0);
`endif
    endtask

    task automatic build(input logic [3:0] op, input logic z, input int waits);
        seq.delete();
        for (int k = 1; k <= 4; k++) push_step(6'(k), 1'($urandom), 1'b0);
        case (op)
            4'd1: begin push_step(6'd8, 1'($urandom), 1'b0); push_mem(6'd9, waits, 6'd10); end
            4'd2: begin push_step(6'd12, 1'($urandom), 1'b0); push_mem(6'd13, waits, 6'd0); end
            4'd3: begin push_step(6'd16, 1'($urandom), 1'b0); push_step(6'd17, 1'($urandom), 1'b0); end
            4'd4: begin push_step(6'd20, 1'($urandom), 1'b0); push_step(6'd21, 1'($urandom), 1'b0); end
            4'd5: push_step(6'd24, 1'($urandom), 1'b0);
            4'd6: if (z) push_step(6'd28, 1'($urandom), 1'b0);
            4'd15: push_step(6'd63, 1'($urandom), 1'b0);
            default: ;
        endcase
    endtask

    // Execute one instruction (or its first `limit` cycles when limit > 0).
    task automatic run_instr(input logic [3:0] op, input logic z, input int waits, input int limit);
        int n;
        build(op, z, waits);
        n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
        for (int i = 0; i < n; i++) begin
            run = (i == 0) ? 1'b1 : 1'($urandom);
            if (m_state == 6'd4) begin
                ir_opcode = m_op;
                z_flag    = m_z;
            end else begin
                ir_opcode = 4'($urandom);
                z_flag    = 1'($urandom);
            end
            mem_ready = (i == 0) ? 1'($urandom) : seq[i-1].mr;
            tick();
            m_state = seq[i].st;
            if (seq[i].to) m_timeout = 1'b1;
            if (m_state == 6'd4) begin
                m_count = m_count + 16'd1;
                m_op    = op;
                m_z     = z;
            end
            check_outputs(i == 0 && m_ill_pending);
            if (i == 0) m_ill_pending = 1'b0;
        end
        if (n == seq.size()) m_ill_pending = (op >= 4'd7 && op <= 4'd14);
    endtask

    // Idle cycles with run low: state must stay put (IDLE or HALT).
    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            run       = 1'b0;
            ir_opcode = 4'($urandom);
            z_flag    = 1'($urandom);
            mem_ready = 1'($urandom);
            tick();
            check_outputs(1'b0);
        end
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        m_state       = 6'd0;
        m_count       = 16'd0;
        m_timeout     = 1'b0;
        m_ill_pending = 1'b0;
        check_outputs(1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        int w;

        // Reset state
        repeat (2) tick();
        check_outputs(1'b0);
        @(negedge clock);
        reset = 1'b0;
        hold(3);

        // Directed instruction mix
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd1, 1'b0, 0, 0);
        run_instr(4'd6, 1'b1, 0, 0);
        run_instr(4'd6, 1'b0, 0, 0);
        run_instr(4'd9, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd15, 1'b0, 0, 0);
        hold(3);
        run_instr(4'd0, 1'b1, 0, 0);
        run_instr(4'd2, 1'b0, 0, 0);
        run_instr(4'd3, 1'b0, 0, 0);
        run_instr(4'd4, 1'b1, 0, 0);
        run_instr(4'd5, 1'b0, 0, 0);
        run_instr(4'd14, 1'b1, 0, 0);
        run_instr(4'd7, 1'b0, 0, 0);

`ifdef SEQ_WAIT_EN
        run_instr(4'd1, 1'b0, 3, 0);
        run_instr(4'd2, 1'b0, WAIT_MAX - 1, 0);
        run_instr(4'd1, 1'b0, WAIT_MAX, 0);
        hold(2);
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd2, 1'b0, WAIT_MAX, 0);
        hold(1);
`endif

        // Randomized instruction stream
        repeat (150) begin
            op = $urandom_range(0, 15);
`ifdef SEQ_WAIT_EN
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WAIT_MAX + 1) : $urandom_range(0, 2);
`else
            w = 0;
`endif
            run_instr(4'(op), 1'($urandom), w, 0);
            if (m_state == 6'd63) hold($urandom_range(0, 3));
        end

        // Asynchronous reset while in STORE2
        run_instr(4'd2, 1'b0, 0, 6);
        async_reset();
        hold(2);
        run_instr(4'd0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
